// File: rtl/kulisch_to_float.sv
// kulisch_to_float: converts a two's-complement fixed-point Kulisch accumulator word into a
// packed {sign, exponent, fraction} float, rounded to nearest-even.
//
// Three-stage pipeline with a valid/ready handshake on both sides:
//   stage 1: sign / magnitude split and zero detect
//   stage 2: leading-one detect, normalize (or subnormal align), guard and sticky
//   stage 3: RNE increment, overflow saturation, pack into the output register
//
// Ports:
//   clock        sole clock, rising edge
//   resetn       synchronous active-low reset
//   in_valid     accIn holds a word to convert
//   in_ready     block accepts accIn this cycle
//   accIn        accumulator value, ACC_DESIRED bits, two's complement
//   out_valid    out_float holds a result
//   out_ready    consumer takes the result this cycle
//   out_float    {sign, exponent, fraction}, EXP_OUT+FRAC_OUT+1 bits
//   out_overflow result saturated to infinity
//   out_inexact  rounding discarded nonzero bits
module kulisch_to_float #(
   parameter int unsigned ACC_DESIRED   = 32,
   parameter int unsigned ACC_FRAC_BITS = 10,
   parameter int unsigned EXP_OUT       = 5,
   parameter int unsigned FRAC_OUT      = 10
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ACC_DESIRED-1:0]       accIn,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [EXP_OUT+FRAC_OUT:0]    out_float,
   output logic                         out_overflow,
   output logic                         out_inexact
);

   localparam int W      = int'(ACC_DESIRED);
   localparam int Bias   = (1 << (EXP_OUT - 1)) - 1;
   localparam int ExpMax = (1 << EXP_OUT) - 1;
   // Left shift that puts the subnormal LSB weight 2^(1-Bias-FRAC_OUT) at the fraction LSB.
   localparam int SubLsRaw = W - 2 - int'(ACC_FRAC_BITS) + Bias;
   localparam int SubRs    = (SubLsRaw < 0) ? -SubLsRaw : 0;
   localparam int SubLs    = (SubLsRaw < 0) ? 0 : SubLsRaw;
   // Zero padding below the magnitude so no shift ever loses a bit; sticky sees everything.
   localparam int LowW = SubRs + int'(FRAC_OUT) + 2;
   localparam int ExtW = W + LowW;
   localparam int PW   = $clog2(W);

   logic advance;

   // Stage 1 state
   logic                   v1_q;
   logic                   sign1_q;
   logic                   zero1_q;
   logic [W-1:0]           mag1_q;
   logic [W-1:0]           mag_in;

   // Stage 2 state
   logic                   v2_q;
   logic                   sign2_q;
   logic                   zero2_q;
   logic                   ovf2_q;
   logic [EXP_OUT-1:0]     exp2_q;
   logic [FRAC_OUT-1:0]    frac2_q;
   logic                   guard2_q;
   logic                   sticky2_q;

   // Stage 2 combinational
   logic [PW-1:0]          lead;
   int                     e_int;
   logic [ExtW-1:0]        ext;
   logic [ExtW-2:0]        aligned;
   logic [FRAC_OUT-1:0]    frac_n;
   logic [EXP_OUT-1:0]     exp_n;
   logic                   guard_n;
   logic                   sticky_n;
   logic                   ovf_n;

   // Stage 3 combinational
   logic                        rnd_inc;
   logic [EXP_OUT+FRAC_OUT-1:0] sum;
   logic                        ovf_r;
   logic [EXP_OUT+FRAC_OUT:0]   res_f;
   logic                        res_o;
   logic                        res_i;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // The most-negative input wraps to 2^(W-1), which is the correct unsigned magnitude.
   assign mag_in = accIn[W-1] ? ({W{1'b0}} - accIn) : accIn;

   always_comb begin
      lead = '0;
      for (int i = 0; i < W; i++) begin
         if (mag1_q[i]) lead = PW'(i);
      end
   end

   always_comb begin
      e_int = int'(lead) - int'(ACC_FRAC_BITS) + Bias;
      ext   = {mag1_q, {LowW{1'b0}}};
      if (e_int >= 1) begin
         // Leading one lands in the dropped top bit; the fraction follows directly below.
         aligned = (ExtW-1)'(ext << (W - 1 - int'(lead)));
      end else if (SubRs > 0) begin
         aligned = (ExtW-1)'(ext >> SubRs);
      end else begin
         aligned = (ExtW-1)'(ext << SubLs);
      end
      frac_n   = aligned[ExtW-2 -: FRAC_OUT];
      guard_n  = aligned[ExtW-2-int'(FRAC_OUT)];
      sticky_n = |aligned[ExtW-3-int'(FRAC_OUT):0];
      ovf_n    = (e_int >= ExpMax);
      exp_n    = (e_int >= 1 && !ovf_n) ? EXP_OUT'(e_int) : '0;
   end

   always_comb begin
      rnd_inc = guard2_q & (sticky2_q | frac2_q[0]);
      // Fraction carry ripples into the exponent; a subnormal carry becomes exponent 1.
      sum     = {exp2_q, frac2_q} + {{(EXP_OUT+FRAC_OUT-1){1'b0}}, rnd_inc};
      ovf_r   = ovf2_q | (&sum[FRAC_OUT +: EXP_OUT]);
      if (zero2_q) begin
         res_f = '0;
         res_o = 1'b0;
         res_i = 1'b0;
      end else if (ovf_r) begin
         res_f = {sign2_q, {EXP_OUT{1'b1}}, {FRAC_OUT{1'b0}}};
         res_o = 1'b1;
         res_i = 1'b1;
      end else begin
         res_f = {sign2_q, sum};
         res_o = 1'b0;
         res_i = guard2_q | sticky2_q;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         v1_q         <= 1'b0;
         sign1_q      <= 1'b0;
         zero1_q      <= 1'b0;
         mag1_q       <= '0;
         v2_q         <= 1'b0;
         sign2_q      <= 1'b0;
         zero2_q      <= 1'b0;
         ovf2_q       <= 1'b0;
         exp2_q       <= '0;
         frac2_q      <= '0;
         guard2_q     <= 1'b0;
         sticky2_q    <= 1'b0;
         out_valid    <= 1'b0;
         out_float    <= '0;
         out_overflow <= 1'b0;
         out_inexact  <= 1'b0;
      end else if (advance) begin
         v1_q <= in_valid;
         if (in_valid) begin
            sign1_q <= accIn[W-1];
            mag1_q  <= mag_in;
            zero1_q <= (mag_in == '0);
         end
         v2_q <= v1_q;
         if (v1_q) begin
            sign2_q   <= sign1_q;
            zero2_q   <= zero1_q;
            ovf2_q    <= ovf_n;
            exp2_q    <= exp_n;
            frac2_q   <= frac_n;
            guard2_q  <= guard_n;
            sticky2_q <= sticky_n;
         end
         out_valid <= v2_q;
         if (v2_q) begin
            out_float    <= res_f;
            out_overflow <= res_o;
            out_inexact  <= res_i;
         end
      end
   end

endmodule

// File: tb/tb_kulisch_to_float.sv
// Bench for kulisch_to_float: two instances (ACC_FRAC_BITS 10 and 30) driven from a vector
// table, with a per-instance scoreboard queue filled on accept and drained on output.
module tb_kulisch_to_float;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        resetn;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf, a_inx;
   logic [31:0] a_acc;
   logic [15:0] a_float;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf, b_inx;
   logic [31:0] b_acc;
   logic [15:0] b_float;

   kulisch_to_float #(.ACC_DESIRED(32), .ACC_FRAC_BITS(10), .EXP_OUT(5), .FRAC_OUT(10)) dut_a (
      .clock(clock), .resetn(resetn), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .accIn(a_acc), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_float(a_float),
      .out_overflow(a_ovf), .out_inexact(a_inx)
   );

   kulisch_to_float #(.ACC_DESIRED(32), .ACC_FRAC_BITS(30), .EXP_OUT(5), .FRAC_OUT(10)) dut_b (
      .clock(clock), .resetn(resetn), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .accIn(b_acc), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_float(b_float),
      .out_overflow(b_ovf), .out_inexact(b_inx)
   );

   typedef struct {
      logic [15:0] f;
      logic        ovf;
      logic        inx;
      int          acc_cyc;
      bit          chk_lat;
   } exp_t;

   typedef struct {
      bit          sel;
      logic [31:0] acc;
      logic [15:0] f;
      logic        ovf;
      logic        inx;
   } vec_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;
   vec_t vecs[22];
   logic [15:0] bp_exp[6] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Call at posedge+2; returns at posedge+2 after the accept edge.
   task automatic send(input bit sel, input logic [31:0] acc, input logic [15:0] f,
                       input logic ovf, input logic inx, input bit chk);
      exp_t r;
      int   waited = 0;
      bit   done = 0;
      if (sel) begin b_in_valid = 1'b1; b_acc = acc; end
      else begin a_in_valid = 1'b1; a_acc = acc; end
      while (!done) begin
         @(negedge clock);
         if (sel ? b_in_ready : a_in_ready) begin
            r.f = f; r.ovf = ovf; r.inx = inx; r.acc_cyc = cyc; r.chk_lat = chk;
            if (sel) q_b.push_back(r);
            else q_a.push_back(r);
            done = 1;
         end else if (++waited > 50) begin
            total++; bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1 (acc %h)", acc);
            done = 1;
         end
         @(posedge clock);
         #2;
      end
      if (sel) b_in_valid = 1'b0;
      else a_in_valid = 1'b0;
   endtask

   always @(negedge clock) begin
      if (resetn && a_out_valid && a_out_ready) begin
         if (q_a.size() == 0) begin
            total++; bad++;
            $display("FAIL a_unexpected: got %h want no output", a_float);
         end else begin
            ea = q_a.pop_front();
            check("a_float", a_float, ea.f);
            check("a_overflow", a_ovf, ea.ovf);
            check("a_inexact", a_inx, ea.inx);
            if (ea.chk_lat) check("a_latency", cyc - ea.acc_cyc, 3);
         end
      end
   end

   always @(negedge clock) begin
      if (resetn && b_out_valid && b_out_ready) begin
         if (q_b.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected: got %h want no output", b_float);
         end else begin
            eb = q_b.pop_front();
            check("b_float", b_float, eb.f);
            check("b_overflow", b_ovf, eb.ovf);
            check("b_inexact", b_inx, eb.inx);
            if (eb.chk_lat) check("b_latency", cyc - eb.acc_cyc, 3);
         end
      end
   end

   task automatic drain();
      int n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
         @(posedge clock);
         n++;
      end
      #2;
      check("drain_a", q_a.size(), 0);
      check("drain_b", q_b.size(), 0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int n;
      int seen;
      resetn = 1'b0;
      a_in_valid = 1'b0; a_acc = '0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_acc = '0; b_out_ready = 1'b0;

      // ACC_FRAC_BITS=10 instance (sel 0) and ACC_FRAC_BITS=30 instance (sel 1)
      vecs[0]  = '{0, 32'h0000_0400, 16'h3C00, 1'b0, 1'b0};
      vecs[1]  = '{0, 32'hFFFF_FC00, 16'hBC00, 1'b0, 1'b0};
      vecs[2]  = '{0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0};
      vecs[3]  = '{0, 32'h0020_0400, 16'h6800, 1'b0, 1'b1};
      vecs[4]  = '{0, 32'h0020_0C00, 16'h6802, 1'b0, 1'b1};
      vecs[5]  = '{0, 32'h7FFF_FFFF, 16'h7C00, 1'b1, 1'b1};
      vecs[6]  = '{0, 32'h8000_0000, 16'hFC00, 1'b1, 1'b1};
      vecs[7]  = '{0, 32'h0000_0200, 16'h3800, 1'b0, 1'b0};
      vecs[8]  = '{0, 32'h0000_0001, 16'h1400, 1'b0, 1'b0};
      vecs[9]  = '{0, 32'h03FF_8000, 16'h7BFF, 1'b0, 1'b0};  // 65504, largest finite
      vecs[10] = '{0, 32'h03FF_C000, 16'h7C00, 1'b1, 1'b1};  // 65520 rounds up past max
      vecs[11] = '{0, 32'h03FF_BC00, 16'h7BFF, 1'b0, 1'b1};  // 65519 rounds down
      vecs[12] = '{0, 32'hFFFF_FFFF, 16'h9400, 1'b0, 1'b0};  // -2^-10
      vecs[13] = '{1, 32'h0000_0040, 16'h0001, 1'b0, 1'b0};  // smallest subnormal
      vecs[14] = '{1, 32'h0000_0001, 16'h0000, 1'b0, 1'b1};
      vecs[15] = '{1, 32'h3FFF_FFC0, 16'h3C00, 1'b0, 1'b1};  // 1-2^-24 rounds to 1.0
      vecs[16] = '{1, 32'h3FF8_0000, 16'h3BFF, 1'b0, 1'b0};  // 1-2^-11 exact
      vecs[17] = '{1, 32'h0000_FFFF, 16'h0400, 1'b0, 1'b1};  // subnormal carry to normal
      vecs[18] = '{1, 32'h0000_0060, 16'h0002, 1'b0, 1'b1};  // 1.5 ulp tie, odd -> up
      vecs[19] = '{1, 32'h0000_0020, 16'h0000, 1'b0, 1'b1};  // 0.5 ulp tie, even -> 0
      vecs[20] = '{1, 32'hFFFF_FFFF, 16'h8000, 1'b0, 1'b1};  // tiny negative keeps sign
      vecs[21] = '{1, 32'h0001_0000, 16'h0400, 1'b0, 1'b0};  // smallest normal

      // Reset state
      @(posedge clock);
      @(negedge clock);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_float", a_float, 0);
      check("rst_overflow", a_ovf, 0);
      check("rst_inexact", a_inx, 0);
      check("rst_b_out_valid", b_out_valid, 0);
      @(posedge clock);
      #2;
      resetn = 1'b1;
      @(negedge clock);
      check("rst_in_ready_a", a_in_ready, 1);
      check("rst_in_ready_b", b_in_ready, 1);
      @(posedge clock);
      #2;
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;

      // Vector table, back to back
      for (int i = 0; i < 22; i++) begin
         send(vecs[i].sel, vecs[i].acc, vecs[i].f, vecs[i].ovf, vecs[i].inx, 1'b1);
      end
      drain();

      // Backpressure: six words streamed while the consumer stalls
      a_out_ready = 1'b0;
      fork
         for (int k = 0; k < 6; k++) send(1'b0, 32'(k + 1) << 10, bp_exp[k], 1'b0, 1'b0, 1'b0);
      join_none
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!a_out_valid && n < 20);
      for (int j = 0; j < 5; j++) begin
         if (j > 0) @(negedge clock);
         check("stall_in_ready", a_in_ready, 0);
         check("stall_out_valid", a_out_valid, 1);
         check("stall_out_float", a_float, 16'h3C00);
      end
      @(posedge clock);
      #2;
      a_out_ready = 1'b1;
      wait fork;
      drain();

      // Reset with three words in flight
      a_out_ready = 1'b0;
      send(1'b0, 32'h0000_1C00, 16'h4700, 1'b0, 1'b0, 1'b0);
      send(1'b0, 32'h0000_2000, 16'h4800, 1'b0, 1'b0, 1'b0);
      send(1'b0, 32'h0000_2400, 16'h4880, 1'b0, 1'b0, 1'b0);
      resetn = 1'b0;
      q_a.delete();
      @(posedge clock);
      #2;
      resetn = 1'b1;
      a_out_ready = 1'b1;
      @(negedge clock);
      check("flush_out_valid", a_out_valid, 0);
      check("flush_in_ready", a_in_ready, 1);
      seen = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clock);
         if (a_out_valid) seen++;
      end
      check("flush_none_emitted", seen, 0);
      @(posedge clock);
      #2;
      send(1'b0, 32'h0000_0400, 16'h3C00, 1'b0, 1'b0, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
